// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Execute-stage multiply/divide unit owning the architectural HI/LO
//            registers. Runs mult/multu/div/divu as a multi-cycle operation
//            whose result is computed at launch and committed after a fixed
//            latency; executes mthi/mtlo in one cycle; serves mfhi/mflo reads.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-high reset, clears all state
//            req        - exception/interrupt request; blocks launch/mthi/mtlo
//            mdu_op     - 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                         7 mfhi,8 mflo, 9..31 none
//            A, B       - rs / rt operands (forwarded)
//            start      - launch of a multiply/divide this cycle (comb.)
//            busy       - operation in flight (registered)
//            real_busy  - start | busy, feeds the stall controller
//            HI, LO     - architectural HI/LO
//            mf_out     - mfhi/mflo read data (comb.), 0 for other ops
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic        real_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mf_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MTHI  = 5'd5;
    localparam logic [4:0] OP_MTLO  = 5'd6;
    localparam logic [4:0] OP_MFHI  = 5'd7;
    localparam logic [4:0] OP_MFLO  = 5'd8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        temp_hi;
    logic [31:0]        temp_lo;
    logic               commit_en;

    logic               is_mult;
    logic               is_div;
    logic               div_zero;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_mag_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_s;
    logic [31:0]        r_s;
    logic [31:0]        b_u_safe;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic [31:0]        next_hi;
    logic [31:0]        next_lo;

    // ------------------------------------------------------------------
    // Launch / stall handshake
    // ------------------------------------------------------------------
    assign is_mult   = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_div    = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign start     = (is_mult || is_div) && !busy && !req;
    assign real_busy = start | busy;
    assign div_zero  = (B == 32'd0);

    always_comb begin
        mf_out = 32'd0;
        if (mdu_op == OP_MFHI) begin
            mf_out = HI;
        end else if (mdu_op == OP_MFLO) begin
            mf_out = LO;
        end
    end

    // ------------------------------------------------------------------
    // Result datapath, evaluated in the launch cycle
    // ------------------------------------------------------------------
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide done on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 instead of hitting an overflowing signed divide.
    assign a_mag      = A[31] ? (~A + 32'd1) : A;
    assign b_mag      = B[31] ? (~B + 32'd1) : B;
    // Zero divisors are replaced by 1 only to keep the datapath X-free; the
    // result is discarded at commit.
    assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s        = A[31] ? (~r_mag + 32'd1) : r_mag;

    assign b_u_safe   = div_zero ? 32'd1 : B;
    assign q_u        = A / b_u_safe;
    assign r_u        = A % b_u_safe;

    always_comb begin
        next_hi = 32'd0;
        next_lo = 32'd0;
        case (mdu_op)
            OP_MULT:  begin next_hi = prod_s[63:32]; next_lo = prod_s[31:0]; end
            OP_MULTU: begin next_hi = prod_u[63:32]; next_lo = prod_u[31:0]; end
            OP_DIV:   begin next_hi = r_s;           next_lo = q_s;          end
            OP_DIVU:  begin next_hi = r_u;           next_lo = q_u;          end
            default:  begin next_hi = 32'd0;         next_lo = 32'd0;        end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            HI        <= 32'd0;
            LO        <= 32'd0;
            temp_hi   <= 32'd0;
            temp_lo   <= 32'd0;
            commit_en <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        temp_hi   <= next_hi;
                        temp_lo   <= next_lo;
                        // Divide by zero still occupies the unit but leaves HI/LO alone.
                        commit_en <= !(is_div && div_zero);
                        cnt       <= is_mult ? MULT_LOAD : DIV_LOAD;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end else if (!req && (mdu_op == OP_MTHI)) begin
                        HI <= A;
                    end else if (!req && (mdu_op == OP_MTLO)) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    // req is deliberately ignored here: the running operation
                    // belongs to an older instruction that is not being flushed.
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        if (commit_en) begin
                            HI <= temp_hi;
                            LO <= temp_lo;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit holding the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi, mtlo and supplies mfhi/mflo read data to the E-stage result mux.
- Produces real_busy, which the stall controller combines with the D-stage MDU op to freeze D when a second MDU instruction arrives.
- Honours the exception/interrupt request so that a flushed instruction never starts or commits an MDU operation.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  1  exception/interrupt request in this cycle; suppresses start and mthi/mtlo writes.
- mdu_op  input  5  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..31 treated as none.
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- start  output  1  combinational; high when mdu_op is 1..4, busy==0 and req==0.
- busy  output  1  registered; high while an operation is in flight.
- real_busy  output  1  combinational, equal to start | busy; goes to the stall controller.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- mf_out  output  32  combinational; HI when op==7, LO when op==8, else 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - busy=0, counter=0, HI=0, LO=0.
  - Pending result is discarded.
  - start/real_busy then follow their combinational definitions.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- IDLE→RUN on a clock edge with start=1:
  - Compute and latch the result into temp_hi/temp_lo at that edge.
  - cnt loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt==1: HI<=temp_hi, LO<=temp_lo, busy<=0, return to IDLE.
- Timing:
  - Start in cycle t gives busy high for cycles t+1..t+N.
  - New HI/LO are visible from cycle t+N+1, with N=MULT_CYCLES or DIV_CYCLES.
- mult: {HI,LO} = signed A × signed B, 64-bit.
- multu: {HI,LO} = unsigned 64-bit product.
- div (signed):
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (B==0, div or divu):
  - Unit still goes busy for DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- mthi/mtlo:
  - When busy==0 and req==0: HI<=A (or LO<=A) at the edge; single cycle, no busy.
- mfhi/mflo: pure read; no state change.
- Ops while busy==1 are ignored: no start, no write.
  - Upstream guarantees this never happens, because the stall controller holds D while real_busy and the D op is nonzero.
- req==1:
  - start forced 0; mthi/mtlo suppressed.
  - An operation already in RUN continues and commits normally; it belongs to an older, non-flushed instruction.
- mf_out during RUN returns the old HI/LO (no stall-free read).
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES))+1.

Test Plan:
- Signed mult, reset released:
  - Stimulus: op=1, A=0xFFFFFFFE (-2), B=3 in cycle t.
  - Response: start=1 and real_busy=1 in t; busy=1 for t+1..t+5; from t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned mult:
  - Stimulus: op=2, A=0xFFFFFFFF, B=2.
  - Response: after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- Signed division:
  - Stimulus: op=3, A=-7 (0xFFFFFFF9), B=2.
  - Response: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus: A=0x80000000, B=0xFFFFFFFF.
  - Response: LO=0x80000000, HI=0.
- Divide by zero and mthi/mtlo:
  - Stimulus: mthi A=0x12345678, mtlo A=0x9ABCDEF0, then divu with B=0.
  - Response: busy for 10 cycles; HI/LO stay 0x12345678/0x9ABCDEF0; mfhi gives mf_out=0x12345678.
- req suppression:
  - Stimulus: op=1 with req=1.
  - Response: start=0, busy stays 0, HI/LO unchanged.
  - Stimulus: mult started, then req=1 during RUN.
  - Response: operation still completes and commits at t+6.
- Reset mid-operation:
  - Stimulus: start div, assert reset asynchronously at cycle t+4.
  - Response: busy=0 immediately, HI=LO=0, and no commit afterwards.
  - Stimulus: after reset, op=7.
  - Response: mf_out=0.
